// File: rtl/noc_pkg.sv
// noc_pkg: definitions shared by the mesh-node PE port logic.
//   DATA_W_DEF  default packet width (mesh link width)
//   VC_BIT_DEF  default bit index of the virtual-channel bit inside a packet
//   COUNT_W     width of the statistics counters
//   state_e     injection sequencer states (IDLE, HOLD)
package noc_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int VC_BIT_DEF = 63;
  localparam int COUNT_W    = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Saturating increment used by the statistics counters.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] value);
    logic [COUNT_W-1:0] result;
    if (value == {COUNT_W{1'b1}}) begin
      result = value;
    end else begin
      result = value + {{(COUNT_W-1){1'b0}}, 1'b1};
    end
    return result;
  endfunction

endpackage

// File: rtl/pe_inject_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
// The search starts at the index just after rr_ptr and wraps from NREQ-1 to 0,
// so the previous winner has the lowest priority.
// Ports:
//   req         in   NREQ    request vector
//   rr_ptr      in   IDX_W   index of the previous winner
//   grant       out  NREQ    one-hot grant (all zero when no request)
//   grant_idx   out  IDX_W   binary index of the granted requester
//   grant_valid out  1       any request granted
module rr_arbiter
  import noc_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  int idx_v;

  // Scan from rr_ptr+1 upward with wrap; the first requester found wins.
  always_comb begin
    grant       = {NREQ{1'b0}};
    grant_idx   = {IDX_W{1'b0}};
    grant_valid = 1'b0;
    idx_v       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx_v = (int'(rr_ptr) + k) % NREQ;
      if (!grant_valid && req[idx_v]) begin
        grant[idx_v] = 1'b1;
        grant_idx    = IDX_W'(idx_v);
        grant_valid  = 1'b1;
      end else begin
        grant_valid = grant_valid;
      end
    end
  end

endmodule

// File: rtl/pe_inject_scheduler.sv
// pe_inject_scheduler: shares a mesh node's PE port between NREQ local
// requesters and terminates the ejection side of the router.
//   Injection: round-robin arbitration (rr_arbiter), one-packet staging
//   register, inject strobe gated by router polarity against the packet's VC bit.
//   Ejection: one-entry receive buffer; pe_ro is the registered "empty" state.
// Optional feature macro: PE_INJ_STATS_EN enables the saturating
// injected/received packet counters; otherwise inj_count/rx_count read 0.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_data    requester packets, slice i at [i*DATA_W +: DATA_W]
//   req_ready             one-hot accept pulse
//   pe_ri/polarity        router injection ready and router polarity
//   pe_si/pe_di           inject strobe and packet
//   pe_so/pe_do/pe_ro     router eject strobe, packet, and our space flag
//   rx_valid/rx_data/rx_ready  receive buffer towards the consumer
//   inj_count/rx_count    statistics counters
module pe_inject_scheduler
  import noc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREQ   = 4,
  parameter int VC_BIT = VC_BIT_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     pe_ri,
  input  logic                     polarity,
  output logic                     pe_si,
  output logic [DATA_W-1:0]        pe_di,
  input  logic                     pe_so,
  input  logic [DATA_W-1:0]        pe_do,
  output logic                     pe_ro,
  output logic                     rx_valid,
  output logic [DATA_W-1:0]        rx_data,
  input  logic                     rx_ready,
  output logic [COUNT_W-1:0]       inj_count,
  output logic [COUNT_W-1:0]       rx_count
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0]   stage_q, stage_d;
  logic                rx_valid_q, rx_valid_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;

  logic [NREQ-1:0]     grant_s;
  logic [IDX_W-1:0]    grant_idx_s;
  logic                grant_valid_s;
  logic                inject_s;
  logic                rx_push_s;
  logic                rx_pop_s;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req         (req_valid),
    .rr_ptr      (rr_ptr_q),
    .grant       (grant_s),
    .grant_idx   (grant_idx_s),
    .grant_valid (grant_valid_s)
  );

  // State register, staging register, arbitration pointer and receive buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= IDX_W'(NREQ - 1);
      stage_q    <= {DATA_W{1'b0}};
      rx_valid_q <= 1'b0;
      rx_data_q  <= {DATA_W{1'b0}};
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      stage_q    <= stage_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
    end
  end

  // Next-state logic of the injection sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_valid_s) begin
          state_d = HOLD;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (inject_s) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer outputs: accept pulse in IDLE, polarity-gated inject strobe in HOLD.
  // The router only takes a packet whose VC bit differs from its current polarity.
  always_comb begin
    req_ready = {NREQ{1'b0}};
    inject_s  = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = grant_s;
        inject_s  = 1'b0;
      end
      HOLD: begin
        req_ready = {NREQ{1'b0}};
        inject_s  = pe_ri & (stage_q[VC_BIT] != polarity);
      end
      default: begin
        req_ready = {NREQ{1'b0}};
        inject_s  = 1'b0;
      end
    endcase
  end

  // Staging path: capture the granted packet and remember the winner for fairness.
  always_comb begin
    stage_d  = stage_q;
    rr_ptr_d = rr_ptr_q;
    if ((state_q == IDLE) && grant_valid_s) begin
      stage_d  = req_data[int'(grant_idx_s)*DATA_W +: DATA_W];
      rr_ptr_d = grant_idx_s;
    end else begin
      stage_d  = stage_q;
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Receive buffer: push only when empty, so a push and a pop never share a cycle;
  // pe_so while full is dropped without touching state.
  always_comb begin
    rx_push_s  = pe_so & ~rx_valid_q;
    rx_pop_s   = rx_valid_q & rx_ready;
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    if (rx_push_s) begin
      rx_valid_d = 1'b1;
      rx_data_d  = pe_do;
    end else if (rx_pop_s) begin
      rx_valid_d = 1'b0;
      rx_data_d  = rx_data_q;
    end else begin
      rx_valid_d = rx_valid_q;
      rx_data_d  = rx_data_q;
    end
  end

  assign pe_si    = inject_s;
  assign pe_di    = stage_q;
  assign pe_ro    = ~rx_valid_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;

`ifdef PE_INJ_STATS_EN
  logic [COUNT_W-1:0] inj_count_q, inj_count_d;
  logic [COUNT_W-1:0] rx_count_q, rx_count_d;

  // Saturating event counters.
  always_comb begin
    inj_count_d = inj_count_q;
    rx_count_d  = rx_count_q;
    if (inject_s) begin
      inj_count_d = sat_inc(inj_count_q);
    end else begin
      inj_count_d = inj_count_q;
    end
    if (rx_push_s) begin
      rx_count_d = sat_inc(rx_count_q);
    end else begin
      rx_count_d = rx_count_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      inj_count_q <= {COUNT_W{1'b0}};
      rx_count_q  <= {COUNT_W{1'b0}};
    end else begin
      inj_count_q <= inj_count_d;
      rx_count_q  <= rx_count_d;
    end
  end

  assign inj_count = inj_count_q;
  assign rx_count  = rx_count_q;
`else
  assign inj_count = {COUNT_W{1'b0}};
  assign rx_count  = {COUNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pe_inject_scheduler.sv
// Directed testbench for pe_inject_scheduler (DATA_W=64, NREQ=4, VC_BIT=63).
// Inputs change 1 time unit after each rising edge; outputs are sampled
// 1 time unit later, well away from the next rising edge.
module tb_pe_inject_scheduler;

  localparam int DW = 64;
  localparam int NR = 4;

  logic             clk;
  logic             reset;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             pe_ri;
  logic             polarity;
  logic             pe_si;
  logic [DW-1:0]    pe_di;
  logic             pe_so;
  logic [DW-1:0]    pe_do;
  logic             pe_ro;
  logic             rx_valid;
  logic [DW-1:0]    rx_data;
  logic             rx_ready;
  logic [15:0]      inj_count;
  logic [15:0]      rx_count;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef PE_INJ_STATS_EN
  localparam logic [15:0] EXP_INJ5 = 16'd5;
  localparam logic [15:0] EXP_RX3  = 16'd3;
`else
  localparam logic [15:0] EXP_INJ5 = 16'd0;
  localparam logic [15:0] EXP_RX3  = 16'd0;
`endif

  pe_inject_scheduler #(.DATA_W(DW), .NREQ(NR), .VC_BIT(63)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .pe_ri     (pe_ri),
    .polarity  (polarity),
    .pe_si     (pe_si),
    .pe_di     (pe_di),
    .pe_so     (pe_so),
    .pe_do     (pe_do),
    .pe_ro     (pe_ro),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .inj_count (inj_count),
    .rx_count  (rx_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
    end
  endtask

  // Advance one clock; the router polarity toggles every cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    polarity = ~polarity;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [DW-1:0] pkt;

  initial begin
    reset = 1'b1; req_valid = 4'b0000; req_data = '0; pe_ri = 1'b1;
    polarity = 1'b0; pe_so = 1'b0; pe_do = 64'h0; rx_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    settle();
    // Reset state
    check("rst_req_ready", 64'(req_ready), 64'h0);
    check("rst_pe_si", 64'(pe_si), 64'h0);
    check("rst_pe_di", pe_di, 64'h0);
    check("rst_pe_ro", 64'(pe_ro), 64'h1);
    check("rst_rx_valid", 64'(rx_valid), 64'h0);
    check("rst_rx_data", rx_data, 64'h0);
    check("rst_inj_count", 64'(inj_count), 64'h0);
    check("rst_rx_count", 64'(rx_count), 64'h0);

    // T1: single requester 0, VC=0; HOLD cycle sees polarity=1 -> inject at once
    polarity = 1'b0;
    pkt = 64'h0123_4567_89AB_CDEF;
    req_data[0 +: DW] = pkt;
    req_valid = 4'b0001;
    settle();
    check("t1_ready_accept", 64'(req_ready), 64'h1);
    tick();
    req_valid = 4'b0000;
    settle();
    check("t1_hold_pol", 64'(polarity), 64'h1);
    check("t1_pe_si", 64'(pe_si), 64'h1);
    check("t1_pe_di", pe_di, pkt);
    check("t1_ready_hold", 64'(req_ready), 64'h0);
    tick();
    settle();
    check("t1_idle_si", 64'(pe_si), 64'h0);

    // T2: all four requesters valid from reset -> grants 0,1,2,3,0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    polarity = 1'b0;
    for (int i = 0; i < NR; i++) begin
      pkt = 64'h1000_0000_0000_00A0 + 64'(i);
      req_data[i*DW +: DW] = pkt;
    end
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      int g;
      g = n % NR;
      settle();
      check("t2_grant", 64'(req_ready), 64'(4'b0001 << g));
      tick();
      settle();
      check("t2_pe_si", 64'(pe_si), 64'h1);
      pkt = 64'h1000_0000_0000_00A0 + 64'(g);
      check("t2_pe_di", pe_di, pkt);
      check("t2_ready_hold", 64'(req_ready), 64'h0);
      tick();
    end
    req_valid = 4'b0000;
    settle();
    check("t2_inj_count", 64'(inj_count), 64'(EXP_INJ5));

    // T3: back-pressure on requester 1 with VC=1
    pkt = 64'h8000_0000_DEAD_BEEF;
    req_data[1*DW +: DW] = pkt;
    req_valid = 4'b0010;
    pe_ri = 1'b0;
    settle();
    check("t3_grant", 64'(req_ready), 64'h2);
    tick();
    req_valid = 4'b0000;
    req_data[1*DW +: DW] = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int c = 0; c < 10; c++) begin
      settle();
      check("t3_bp_si", 64'(pe_si), 64'h0);
      check("t3_bp_stage", pe_di, pkt);
      tick();
    end
    pe_ri = 1'b1;
    settle();
    // polarity is 1 here, equal to the VC bit -> still blocked
    check("t3_pol_block", 64'(pe_si), 64'h0);
    tick();
    settle();
    check("t3_inject", 64'(pe_si), 64'h1);
    check("t3_inject_di", pe_di, pkt);
    tick();
    settle();
    check("t3_back_idle_si", 64'(pe_si), 64'h0);

    // T4: receive buffer
    pe_so = 1'b1; pe_do = 64'hAAAA_0000_0000_0001;
    settle();
    check("t4_ro_empty", 64'(pe_ro), 64'h1);
    tick();
    pe_so = 1'b1; pe_do = 64'hBBBB_0000_0000_0002;
    settle();
    check("t4_rx_valid", 64'(rx_valid), 64'h1);
    check("t4_ro_full", 64'(pe_ro), 64'h0);
    check("t4_rx_data", rx_data, 64'hAAAA_0000_0000_0001);
    tick();
    pe_so = 1'b0;
    settle();
    check("t4_ignored", rx_data, 64'hAAAA_0000_0000_0001);
    rx_ready = 1'b1;
    settle();
    check("t4_pop_ro", 64'(pe_ro), 64'h0);
    tick();
    rx_ready = 1'b0;
    settle();
    check("t4_popped_ro", 64'(pe_ro), 64'h1);
    check("t4_popped_valid", 64'(rx_valid), 64'h0);
    pe_so = 1'b1; pe_do = 64'hCCCC_0000_0000_0003;
    tick();
    // pop and an attempted push in the same cycle: push refused
    pe_do = 64'hDDDD_0000_0000_0004;
    rx_ready = 1'b1;
    settle();
    check("t4_second_data", rx_data, 64'hCCCC_0000_0000_0003);
    tick();
    rx_ready = 1'b0;
    settle();
    check("t4_no_push_on_pop", 64'(rx_valid), 64'h0);
    tick();
    pe_so = 1'b0;
    settle();
    check("t4_third_data", rx_data, 64'hDDDD_0000_0000_0004);
    check("t4_rx_count", 64'(rx_count), 64'(EXP_RX3));

    // T5: reset while in HOLD and with rx full
    pkt = 64'h0000_0000_0000_3333;
    req_data[3*DW +: DW] = pkt;
    req_valid = 4'b1000;
    pe_ri = 1'b0;
    settle();
    check("t5_grant3", 64'(req_ready), 64'h8);
    tick();
    req_valid = 4'b0000;
    settle();
    check("t5_hold_di", pe_di, pkt);
    reset = 1'b1;
    pe_ri = 1'b1;
    tick();
    reset = 1'b0;
    req_valid = 4'b1111;
    settle();
    check("t5_si", 64'(pe_si), 64'h0);
    check("t5_ro", 64'(pe_ro), 64'h1);
    check("t5_rx_valid", 64'(rx_valid), 64'h0);
    check("t5_req0_first", 64'(req_ready), 64'h1);
    check("t5_inj_cleared", 64'(inj_count), 64'h0);
    req_valid = 4'b0000;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
